// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: run/pause/adjust/clear sequencing, MM:SS BCD count and blink flags.
// Optional lap-hold display feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59
) (
  input  logic       CLK_REF,
  input  logic       CLK_RES_N,
  input  logic       TICK_1HZ,
  input  logic       TICK_2HZ,
  input  logic       BTN_PAUSE,
  input  logic       BTN_RST,
  input  logic       BTN_ADJ,
  input  logic       BTN_SEL,
`ifdef STOPWATCH_LAP_EN
  input  logic       BTN_LAP,
`endif
  output logic [3:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       BLANK_MIN,
  output logic       BLANK_SEC,
  output logic [1:0] STATE
);

  localparam logic [1:0] ST_PAUSED = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_ADJUST = 2'b10;
  localparam logic [3:0] MAX_T     = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O     = 4'(MAX_MIN % 10);

  logic       r_tick1_q, r_tick2_q, r_pause_q, r_rst_q;
  logic [1:0] r_state;
  logic       r_phase;
  logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic       r_blank_min, r_blank_sec;

  logic       w_rise1, w_rise2, w_rise_pause, w_rise_rst;
  logic       w_sec_wrap, w_min_wrap;
  logic [3:0] w_sec_inc_t, w_sec_inc_o, w_min_inc_t, w_min_inc_o;
  logic [1:0] w_nxt_state;
  logic       w_nxt_phase;
  logic [3:0] w_nxt_min_t, w_nxt_min_o, w_nxt_sec_t, w_nxt_sec_o;

  assign w_rise1      = TICK_1HZ  & ~r_tick1_q;
  assign w_rise2      = TICK_2HZ  & ~r_tick2_q;
  assign w_rise_pause = BTN_PAUSE & ~r_pause_q;
  assign w_rise_rst   = BTN_RST   & ~r_rst_q;

  // Per-field BCD increments; each wraps on its own, carry is applied only in RUN.
  assign w_sec_wrap  = (r_sec_t == 4'd5) && (r_sec_o == 4'd9);
  assign w_sec_inc_o = (r_sec_o == 4'd9) ? 4'd0 : r_sec_o + 4'd1;
  assign w_sec_inc_t = (r_sec_o != 4'd9) ? r_sec_t : (w_sec_wrap ? 4'd0 : r_sec_t + 4'd1);
  assign w_min_wrap  = (r_min_t == MAX_T) && (r_min_o == MAX_O);
  assign w_min_inc_o = (w_min_wrap || r_min_o == 4'd9) ? 4'd0 : r_min_o + 4'd1;
  assign w_min_inc_t = w_min_wrap ? 4'd0 : ((r_min_o == 4'd9) ? r_min_t + 4'd1 : r_min_t);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase ^ w_rise2;
    w_nxt_min_t = r_min_t;
    w_nxt_min_o = r_min_o;
    w_nxt_sec_t = r_sec_t;
    w_nxt_sec_o = r_sec_o;
    if (w_rise_rst) begin
      w_nxt_state = ST_PAUSED;
      w_nxt_min_t = 4'd0;
      w_nxt_min_o = 4'd0;
      w_nxt_sec_t = 4'd0;
      w_nxt_sec_o = 4'd0;
    end else if (BTN_ADJ) begin
      w_nxt_state = ST_ADJUST;
      if (r_state != ST_ADJUST) begin
        w_nxt_phase = 1'b0;
      end else if (w_rise2) begin
        if (BTN_SEL) begin
          w_nxt_sec_t = w_sec_inc_t;
          w_nxt_sec_o = w_sec_inc_o;
        end else begin
          w_nxt_min_t = w_min_inc_t;
          w_nxt_min_o = w_min_inc_o;
        end
      end
    end else if (r_state == ST_ADJUST) begin
      w_nxt_state = ST_PAUSED;
    end else begin
      if (w_rise_pause)
        w_nxt_state = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
      // Tick uses the pre-transition state, so a coincident pause press still counts when running.
      if (r_state == ST_RUN && w_rise1) begin
        w_nxt_sec_t = w_sec_inc_t;
        w_nxt_sec_o = w_sec_inc_o;
        if (w_sec_wrap) begin
          w_nxt_min_t = w_min_inc_t;
          w_nxt_min_o = w_min_inc_o;
        end
      end
    end
  end

  always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
    if (!CLK_RES_N) begin
      r_tick1_q   <= 1'b1;
      r_tick2_q   <= 1'b1;
      r_pause_q   <= 1'b1;
      r_rst_q     <= 1'b1;
      r_state     <= ST_PAUSED;
      r_phase     <= 1'b0;
      r_min_t     <= 4'd0;
      r_min_o     <= 4'd0;
      r_sec_t     <= 4'd0;
      r_sec_o     <= 4'd0;
      r_blank_min <= 1'b0;
      r_blank_sec <= 1'b0;
    end else begin
      r_tick1_q   <= TICK_1HZ;
      r_tick2_q   <= TICK_2HZ;
      r_pause_q   <= BTN_PAUSE;
      r_rst_q     <= BTN_RST;
      r_state     <= w_nxt_state;
      r_phase     <= w_nxt_phase;
      r_min_t     <= w_nxt_min_t;
      r_min_o     <= w_nxt_min_o;
      r_sec_t     <= w_nxt_sec_t;
      r_sec_o     <= w_nxt_sec_o;
      r_blank_min <= (w_nxt_state == ST_ADJUST) && !BTN_SEL && w_nxt_phase;
      r_blank_sec <= (w_nxt_state == ST_ADJUST) &&  BTN_SEL && w_nxt_phase;
    end
  end

  assign STATE     = r_state;
  assign BLANK_MIN = r_blank_min;
  assign BLANK_SEC = r_blank_sec;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_q, r_hold;
  logic [3:0] r_disp_min_t, r_disp_min_o, r_disp_sec_t, r_disp_sec_o;
  logic       w_rise_lap, w_nxt_hold;

  assign w_rise_lap = BTN_LAP & ~r_lap_q;

  // Display tracks the live count whenever not holding; latching simply stops the reload.
  always_comb begin
    w_nxt_hold = r_hold;
    if (w_rise_rst || (BTN_ADJ && r_state != ST_ADJUST))
      w_nxt_hold = 1'b0;
    else if (w_rise_lap && r_state == ST_RUN && !BTN_ADJ)
      w_nxt_hold = ~r_hold;
  end

  always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
    if (!CLK_RES_N) begin
      r_lap_q      <= 1'b1;
      r_hold       <= 1'b0;
      r_disp_min_t <= 4'd0;
      r_disp_min_o <= 4'd0;
      r_disp_sec_t <= 4'd0;
      r_disp_sec_o <= 4'd0;
    end else begin
      r_lap_q <= BTN_LAP;
      r_hold  <= w_nxt_hold;
      if (!w_nxt_hold) begin
        r_disp_min_t <= w_nxt_min_t;
        r_disp_min_o <= w_nxt_min_o;
        r_disp_sec_t <= w_nxt_sec_t;
        r_disp_sec_o <= w_nxt_sec_o;
      end
    end
  end

  assign MIN_TENS = r_disp_min_t;
  assign MIN_ONES = r_disp_min_o;
  assign SEC_TENS = r_disp_sec_t;
  assign SEC_ONES = r_disp_sec_o;
`else
  assign MIN_TENS = r_min_t;
  assign MIN_ONES = r_min_o;
  assign SEC_TENS = r_sec_t;
  assign SEC_ONES = r_sec_o;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and count core of the stopwatch. Consumes the level outputs of the clock divider (CLK_1HZ, CLK_2HZ) as tick sources and the debounced buttons.
- Sequences run/pause/adjust/clear and keeps an MM:SS BCD count.
- Drives digits plus per-field blank flags to the 7-segment display mux.
- Single clock domain: CLK_REF.

Parameters:
- MAX_MIN, 59, terminal value of the minutes field (legal 1..99); MAX_MIN:59 wraps to 00:00.

Ports:
- CLK_REF  in  1  system clock (same CLK_REF that feeds the divider)
- CLK_RES_N  in  1  asynchronous active-low reset
- TICK_1HZ  in  1  divider 1 Hz level, CLK_REF-synchronous
- TICK_2HZ  in  1  divider 2 Hz level, CLK_REF-synchronous
- BTN_PAUSE  in  1  debounced level; rising edge toggles run/pause
- BTN_RST  in  1  debounced level; rising edge clears count
- BTN_ADJ  in  1  level; high = adjust mode
- BTN_SEL  in  1  level; 0 = adjust minutes, 1 = adjust seconds
- MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES  out  4 each  BCD digits, registered
- BLANK_MIN, BLANK_SEC  out  1 each  registered; 1 = display blanks that field
- STATE  out  2  00 PAUSED, 01 RUN, 10 ADJUST (11 unused)

Behaviour:
- Reset (CLK_RES_N low, async):
  - all digits 0, STATE=PAUSED, BLANK_*=0, blink phase=0.
  - Edge-history flops for TICK_1HZ/TICK_2HZ/BTN_PAUSE/BTN_RST reset to 1, so an input held high through reset release produces no edge.
- Edge detect: x_rise = x & ~x_q, where x_q is the previous-cycle sample. Action occurs on the same CLK_REF edge at which x is first sampled high; outputs are visible one cycle after the input rises.
- FSM, evaluated per cycle in priority order:
  1. BTN_RST rise: digits to 00:00, state to PAUSED. Wins over everything, including ADJ high and a coincident tick.
  2. BTN_ADJ high: state to ADJUST from any state. BTN_PAUSE rises are ignored while in ADJUST.
  3. BTN_ADJ low in ADJUST: to PAUSED next cycle. Never resumes RUN directly.
  4. BTN_PAUSE rise: PAUSED to RUN, RUN to PAUSED. A coincident TICK_1HZ rise in that cycle is applied only if the pre-transition state was RUN.
- RUN counting, per TICK_1HZ rise:
  - Seconds +1 in BCD; SEC_ONES 9 to 0 carries into SEC_TENS.
  - Seconds 59 goes to 00 and carries +1 into minutes.
  - Minutes at MAX_MIN with carry go to 00.
  - Full wrap: MAX_MIN:59 to 00:00.
- PAUSED: digits hold; ticks ignored.
- ADJUST:
  - Each TICK_2HZ rise increments only the selected field by 1, with no carry between fields.
  - Seconds wrap 59 to 00; minutes wrap MAX_MIN to 00.
  - BTN_SEL is sampled per cycle; changing it mid-adjust takes effect on the next tick.
- Blink:
  - Phase flop toggles on every TICK_2HZ rise in all states; it is cleared when ADJUST is entered.
  - BLANK_MIN = (STATE==ADJUST && SEL==0 && phase); BLANK_SEC = (STATE==ADJUST && SEL==1 && phase).
  - Both BLANK_* are 0 outside ADJUST.
- Digits are always valid BCD: no digit ever exceeds 9, SEC_TENS never exceeds 5.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input BTN_LAP (1 bit, debounced level; edge flop resets to 1).
  - First BTN_LAP rise in RUN latches the current count into the display registers; the display then holds while the internal count keeps running.
  - Second rise releases the display back to the live count in the same cycle.
  - BTN_RST rise or entering ADJUST also releases the hold.
  - BTN_LAP rise in PAUSED/ADJUST is ignored.
- Undefined: no BTN_LAP port; the digit outputs always equal the live count.

Test Plan:
- Reset release with BTN_PAUSE held high -> STATE=00, digits 00:00, no transition to RUN.
- PAUSE rise, then 61 TICK_1HZ rises -> 01:01; a further PAUSE rise plus 5 ticks -> remains 01:01.
- Preload via adjust to 59:58 (MAX_MIN=59), RUN, 2 ticks -> 00:00 with no out-of-range BCD on any cycle.
- ADJ=1, SEL=1, 3 TICK_2HZ rises from 00:58 -> 00:01, minutes unchanged; BLANK_SEC toggles per tick, BLANK_MIN stays 0.
- BTN_RST rise coincident with TICK_1HZ rise in RUN at 12:34 -> next cycle 00:00, STATE=PAUSED.
- STOPWATCH_LAP_EN: RUN at 00:10, LAP rise, 5 ticks -> display 00:10; second LAP rise -> display 00:15.
